// File: rtl/cb_pkg.sv
// Shared types and elaboration helpers for the time-shared carry-bypass adder.
package cb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  function automatic int nchunk(input int width, input int chunk);
    return width / chunk;
  endfunction

  function automatic bit cfg_ok(input int width, input int chunk);
    return (chunk >= 4) && (chunk % 4 == 0) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/cbAdder.sv
// Carry-bypass adder built from 4-bit ripple groups; a fully propagating group
// forwards its carry-in directly to the next group.
module cbAdder #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NGRP = WIDTH / 4;

  logic grp_cin;
  logic rip_c;
  logic all_p;
  logic p_bit;

  always_comb begin
    sum     = '0;
    grp_cin = cin;
    rip_c   = 1'b0;
    all_p   = 1'b0;
    p_bit   = 1'b0;
    for (int g = 0; g < NGRP; g++) begin
      rip_c = grp_cin;
      all_p = 1'b1;
      for (int i = 0; i < 4; i++) begin
        p_bit          = a[g*4+i] ^ b[g*4+i];
        sum[g*4+i]     = p_bit ^ rip_c;
        rip_c          = (a[g*4+i] & b[g*4+i]) | (p_bit & rip_c);
        all_p          = all_p & p_bit;
      end
      grp_cin = all_p ? grp_cin : rip_c;
    end
    cout = grp_cin;
  end

endmodule

// File: rtl/cb_seq_adder_arb.sv
// Two-requester round-robin front end feeding one CHUNK-bit adder that is
// stepped LSB slice first across WIDTH-bit operands.
module cb_seq_adder_arb
  import cb_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic             req0_cin,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic             req1_cin,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_sum,
  output logic             res_cout,
  output logic             res_id
);

  localparam int NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int IW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IW-1:0] LAST = IW'(NCHUNK - 1);

  if (!cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
    $error("cb_seq_adder_arb: WIDTH must be a multiple of CHUNK, CHUNK a multiple of 4");
  end

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             carry;
  logic [IW-1:0]    idx;
  logic             last_grant;

  logic             grant;
  logic             any_valid;
  logic             accept;
  logic [CHUNK-1:0] slice_a;
  logic [CHUNK-1:0] slice_b;
  logic [CHUNK-1:0] slice_sum;
  logic             slice_cout;

  // Round-robin: a lone requester wins outright, a tie goes to the one not served last.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) grant = ~last_grant;
    else if (req1_valid)          grant = 1'b1;
  end

  assign any_valid  = req0_valid | req1_valid;
  assign req0_ready = rst_n && (state == IDLE) && any_valid && !grant;
  assign req1_ready = rst_n && (state == IDLE) && any_valid &&  grant;
  assign accept     = (req0_valid && req0_ready) || (req1_valid && req1_ready);

  assign slice_a = op_a[idx*CHUNK +: CHUNK];
  assign slice_b = op_b[idx*CHUNK +: CHUNK];

  cbAdder #(.WIDTH(CHUNK)) u_slice (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (carry),
    .sum  (slice_sum),
    .cout (slice_cout)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_a       <= '0;
      op_b       <= '0;
      carry      <= 1'b0;
      idx        <= '0;
      last_grant <= 1'b1;
      res_valid  <= 1'b0;
      res_sum    <= '0;
      res_cout   <= 1'b0;
      res_id     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            op_a       <= grant ? req1_a   : req0_a;
            op_b       <= grant ? req1_b   : req0_b;
            carry      <= grant ? req1_cin : req0_cin;
            idx        <= '0;
            last_grant <= grant;
            res_id     <= grant;
            state      <= RUN;
          end
        end
        RUN: begin
          // Partial sums land in place; res_sum is only meaningful once res_valid rises.
          res_sum[idx*CHUNK +: CHUNK] <= slice_sum;
          carry                       <= slice_cout;
          if (idx == LAST) begin
            res_cout  <= slice_cout;
            res_valid <= 1'b1;
            idx       <= '0;
            state     <= DONE;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
